// File: rtl/cplx_result_reader.sv
// cplx_result_reader: buffers packed {real, imag} results in a FIFO and streams each
// as two 32-bit beats, real first, over a valid/ready interface.
module cplx_result_reader #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_done,
    input  logic [63:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_is_im,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND_RE, SEND_IM} state_t;

    state_t           r_state, w_next;
    logic [63:0]      r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic             r_overflow;
    logic             w_push, w_pop;
    logic [63:0]      w_head;

    assign in_ready     = r_count != CNT_W'(DEPTH);
    assign w_push       = in_done && in_ready;
    assign w_pop        = (r_state == SEND_IM) && out_ready;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_head       = r_mem[r_rd_ptr];
    assign count        = r_count;
    assign overflow     = r_overflow;

    always_ff @(posedge clock)
        if (w_push) r_mem[r_wr_ptr] <= in_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next;
            r_count <= w_count_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (in_done && !in_ready) r_overflow <= 1'b1;
        end
    end

    // Moving to SEND_RE straight from SEND_IM keeps back-to-back entries bubble-free.
    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        out_is_im = 1'b0;
        out_data  = '0;
        case (r_state)
            IDLE: if (r_count != '0) w_next = SEND_RE;
            SEND_RE: begin
                out_valid = 1'b1;
                out_data  = w_head[63:32];
                if (out_ready) w_next = SEND_IM;
            end
            SEND_IM: begin
                out_valid = 1'b1;
                out_is_im = 1'b1;
                out_data  = w_head[31:0];
                if (out_ready) w_next = (w_count_next != '0) ? SEND_RE : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cplx_result_reader.sv
// tb_cplx_result_reader: directed and random stimulus checked against a beat-queue
// reference model of the result reader.
module tb_cplx_result_reader;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clock = 1'b0;
    logic             reset, in_done, out_ready;
    logic [63:0]      in_data;
    logic             in_ready, out_valid, out_is_im, overflow;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] count;

    cplx_result_reader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .in_done(in_done), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_is_im(out_is_im), .count(count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          fails  = 0;
    logic [32:0] q[$];
    logic        exp_valid, exp_ovf;

    // Each stored word is two pending beats; an entry counts until its imaginary beat leaves.
    function automatic int mcount();
        return (q.size() + 1) / 2;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic d, input logic [63:0] data, input logic r);
        int          c;
        logic        hs, push;
        logic [32:0] b;
        c = mcount();
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) chk("beat", 64'({out_is_im, out_data}), 64'(q[0]));
        chk("count", 64'(count), 64'(c));
        chk("in_ready", 64'(in_ready), 64'(c != DEPTH));
        chk("overflow", 64'(overflow), 64'(exp_ovf));
        in_done   = d;
        in_data   = data;
        out_ready = r;
        hs   = exp_valid && r;
        push = d && (c != DEPTH);
        if (d && !push) exp_ovf = 1'b1;
        b = '0;
        if (hs) b = q.pop_front();
        if (push) begin
            q.push_back({1'b0, data[63:32]});
            q.push_back({1'b1, data[31:0]});
        end
        if (!exp_valid) exp_valid = (c != 0);
        else if (hs && b[32]) exp_valid = (mcount() != 0);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_done   = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_out_is_im", 64'(out_is_im), 64'h0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 64'h0, 1'b1);
    endtask

    initial begin
        reset     = 1'b1;
        in_done   = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) @(negedge clock);
        do_reset();
        step(1'b0, 64'h0, 1'b1);
        step(1'b1, 64'h00000005_00000003, 1'b1);
        drain(4);
        step(1'b1, 64'h11111111_22222222, 1'b0);
        repeat (5) step(1'b0, 64'h0, 1'b0);
        drain(4);
        for (int i = 1; i <= 5; i++) step(1'b1, {32'(i), 32'(i)}, 1'b0);
        chk("full_overflow", 64'(overflow), 64'h1);
        chk("full_count", 64'(count), 64'(DEPTH));
        drain(10);
        do_reset();
        step(1'b1, 64'hC0000000_00000000, 1'b1);
        step(1'b1, 64'hC0000001_00000001, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, {$urandom, $urandom}, 1'b1);
            step(1'b0, 64'h0, 1'b1);
        end
        drain(8);
        step(1'b1, 64'hAAAAAAAA_BBBBBBBB, 1'b0);
        step(1'b1, {$urandom, $urandom}, 1'b0);
        step(1'b1, {$urandom, $urandom}, 1'b0);
        for (int i = 0; i < 10 && !(exp_valid && q[0] == {1'b1, 32'hBBBBBBBB}); i++)
            step(1'b0, 64'h0, 1'b1);
        chk("reached_send_im", 64'(exp_valid && q[0] == {1'b1, 32'hBBBBBBBB}), 64'h1);
        do_reset();
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_count", 64'(count), 64'h0);
        step(1'b0, 64'h0, 1'b1);
        step(1'b0, 64'h0, 1'b1);
        step(1'b1, 64'h00000007_00000008, 1'b1);
        drain(4);
        step(1'b1, 64'hFFFFFFFE_80000000, 1'b1);
        drain(4);
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
        drain(12);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/cplx_result_reader.md
Name: cplx_result_reader

Overview:
- Consumer side of the packed complex-result interface produced by the add/sub and arithmetic units.
- Accepts 64-bit packed complex words {real[63:32], imag[31:0]} qualified by a done strobe and buffers them in a small FIFO.
- Serializes each word as two 32-bit beats, real first then imaginary, over a valid/ready stream toward the output/display path.

Parameters:
- DEPTH, 4, number of 64-bit entries in the FIFO (power of two, 2..16).
- CNT_W, 3, width of the occupancy count (log2(DEPTH)+1).

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_done  input  1  producer strobe; in_data valid this cycle
- in_data  input  64  packed complex result {real, imag}
- in_ready  output  1  FIFO not full; a word is stored only when in_done && in_ready
- out_valid  output  1  out_data holds a valid beat
- out_ready  input  1  downstream accepts the beat when out_valid && out_ready
- out_data  output  32  current beat: real or imaginary half of the FIFO head
- out_is_im  output  1  0 = real beat, 1 = imaginary beat
- count  output  CNT_W  number of stored (not fully sent) entries
- overflow  output  1  sticky: in_done seen while in_ready = 0

Behaviour:
- Reset: one synchronous, active-high reset, applied mid-operation the same as at power-up. It discards all FIFO contents and partial beats and sets the following values:
  - count = 0, in_ready = 1
  - out_valid = 0, out_is_im = 0, out_data = 0
  - overflow = 0
  - FSM = IDLE
  - read and write pointers = 0
- Write side:
  - A push occurs when in_done && in_ready, storing in_data at the write pointer; the pointer increments modulo DEPTH.
  - in_ready = (count != DEPTH), registered-state derived and not dependent on same-cycle pop.
  - in_done while full drops the word, leaves FIFO state unchanged and sets overflow = 1. overflow is cleared only by reset.
- FSM states: IDLE, SEND_RE, SEND_IM.
  - IDLE: out_valid = 0. If count != 0 at the clock edge, go to SEND_RE.
  - SEND_RE: out_valid = 1, out_is_im = 0, out_data = head[63:32]. On handshake, go to SEND_IM. Otherwise hold, with out_data stable.
  - SEND_IM: out_valid = 1, out_is_im = 1, out_data = head[31:0]. On handshake:
    - pop: read pointer +1 modulo DEPTH
    - if count after pop != 0, go to SEND_RE; else go to IDLE.
- Latency: a word pushed at edge N produces count = 1 after edge N. The FSM enters SEND_RE at edge N+1, so the first beat is visible in cycle N+1 → N+2 (2 cycles push-to-beat from IDLE).
- Back-to-back throughput: one beat per cycle while out_ready = 1 and the FIFO is non-empty; no bubble between entries.
- Simultaneous push and pop in the same cycle:
  - count unchanged; both pointers advance.
  - Allowed whenever not full at the start of the cycle.
  - When full, the push is refused even if a pop occurs that cycle, and overflow is set.
- out_data and out_is_im must not change while out_valid && !out_ready.
- Pointer wrap: after DEPTH pushes, the write pointer returns to 0. Data order is strictly FIFO across the wrap.
- Arithmetic: no interpretation of the data. Halves are passed bit-exact; signed values such as 0xFFFFFFFF are passed unchanged.

Test Plan:
- Single word: after reset, push 0x00000005_00000003 with out_ready = 1.
  - Expected: beats 0x00000005 (is_im = 0) then 0x00000003 (is_im = 1) on consecutive cycles, then out_valid = 0 and count = 0.
- Backpressure: push 0x11111111_22222222 with out_ready = 0 for 5 cycles, then 1.
  - Expected: out_data holds 0x11111111 stable for those 5 cycles, then the 2 beats complete; overflow = 0.
- Fill and overflow (DEPTH = 4): push 5 words 0x1_1 … 0x5_5 on consecutive cycles with out_ready = 0.
  - Expected: in_ready = 0 after the 4th push, the 5th word is dropped, overflow = 1, count = 4.
  - Draining then yields only words 1..4, in order.
- Simultaneous push/pop and wrap: keep count = 2 while streaming 10 words continuously with out_ready = 1.
  - Expected: all 20 beats arrive in order with no gaps after the first, and the pointers wrap twice.
- Reset mid-operation: assert reset during SEND_IM of word 0xAAAAAAAA_BBBBBBBB with 2 further words queued.
  - Expected: next cycle out_valid = 0, count = 0, in_ready = 1, overflow = 0.
  - No stale beats after reset; a fresh push 0x7_8 yields 0x7, 0x8.
- Sign pass-through: push 0xFFFFFFFE_80000000.
  - Expected: beats 0xFFFFFFFE then 0x80000000, bit-exact.
